fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
PC/fetch stage directly upstream of the single-cycle register-file/ALU/data-memory datapath. Holds the PC and issues one request at a time to an instruction memory with variable read latency. Presents Instr/PC/PCPlus4 with a valid flag and stalls while downstream is busy. Resolves the next PC from the branch/jump controls and the ALU flags (Zero, signedLess, unsignedLess) that the datapath returns.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
XLEN, 32, address/data width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous.
imem_req  out  1  one-cycle pulse requesting the word at imem_addr.
imem_addr  out  32  fetch address; equals PC while imem_req=1.
imem_rvalid  in  1  response valid; in order, at most one outstanding, latency >=1 cycle.
imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
stall  in  1  downstream not ready; holds the current instruction.
flush  in  1  asynchronous-to-flow redirect (trap/debug) to flush_pc.
flush_pc  in  32  flush target.
Branch  in  1  current instruction is a conditional branch.
BranchType  in  3  funct3 of the branch.
Jump  in  1  JAL.
JumpReg  in  1  JALR.
ImmExt  in  32  sign-extended immediate.
SrcA  in  32  rs1 value, used for JALR.
Zero, signedLess, unsignedLess  in  1 each  ALU flags for the current instruction.
instr_valid  out  1  Instr/PC/PCPlus4 are valid.
Instr  out  32  fetched instruction.
PC  out  32  address of Instr.
PCPlus4  out  32  PC+4, mod 2^32.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, kill=0. imem_addr=pc throughout.
- State IDLE: the cycle after reset release. Goes to REQ.
- State REQ: imem_req=1. Goes to WAIT.
- State WAIT: on imem_rvalid, latch Instr<=imem_rdata and go to VALID. If kill=1, drop the data, clear kill and go to REQ.
- State VALID: instr_valid=1. Outputs are stable while stall=1.
- Consume: instr_valid=1 and stall=0. Load pc with next_pc and go to REQ. Branch/jump inputs and flags are sampled only on the consume cycle.
- Minimum cadence with 1-cycle memory latency: REQ(t), rvalid(t+1), VALID(t+2). One instruction per 3 cycles.
- next_pc priority:
  - JumpReg: (SrcA+ImmExt) & ~32'h1.
  - Jump: PC+ImmExt.
  - Branch and taken: PC+ImmExt.
  - Otherwise: PC+4.
  - All additions are 32-bit and wrap.
- Branch taken by BranchType:
  - 000: Zero.
  - 001: !Zero.
  - 100: signedLess.
  - 101: !signedLess.
  - 110: unsignedLess.
  - 111: !unsignedLess.
  - 010/011: not taken.
- Target alignment: no alignment check. The address is issued as computed.
- flush (highest priority, any state): pc<=flush_pc, instr_valid<=0, next state REQ.
  - In WAIT without same-cycle rvalid: set kill=1 and go to WAIT, so the stale response is dropped before the new request.
  - In WAIT with same-cycle rvalid: drop the data and go to REQ.
  - flush with stall=1: flush wins.
  - flush in REQ: the just-issued request is outstanding, so set kill=1 and go to WAIT.
- Reset mid-operation: return to reset values immediately. Any response arriving after reset is ignored because state is IDLE/REQ, not WAIT.
- imem_rvalid outside WAIT is ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched[31:0] (+1 per consume) and perf_redirects[31:0] (+1 per consume with next_pc != PC+4, and +1 per flush).
  - Both counters wrap at 2^32.
  - Both reset to 0 on rst_n.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory latency 1, rdata=32'h00500093, stall=0 → imem_req at cycle 1 with addr 0. instr_valid at cycle 3 with PC=0, PCPlus4=4. Next req addr=4.
- BEQ at PC=0x10, ImmExt=-8, Zero=1 → next imem_addr=0x08. Same with Zero=0 → 0x14.
- JALR: SrcA=0x101, ImmExt=0x4 → next imem_addr=0x104 (bit0 cleared). Jump=1 and JumpReg=1 together → JALR target used.
- stall held 5 cycles in VALID → Instr/PC unchanged and no imem_req. Release → one req to PC+4.
- Memory latency 4, flush with flush_pc=0x200 one cycle after req → old response discarded, instr_valid stays 0. Next req addr=0x200 and its data is presented.
- PC=32'hFFFF_FFFC, sequential → PCPlus4=0 and next fetch addr=0. rst_n pulsed low while in WAIT → outputs return to reset values in the same cycle, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Purpose: PC/fetch stage; keeps the PC, fetches one word at a time from a variable-latency
//          instruction memory and resolves the next PC from branch/jump controls and ALU flags.
// Latency: REQ -> response (>=1 cycle) -> VALID; 3 cycles per instruction with a 1-cycle memory.
// Backpressure: stall holds Instr/PC/PCPlus4 and suppresses new requests; flush overrides stall.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset (synchronous release)
//   imem_req / imem_addr    one-cycle request pulse; address always mirrors the PC
//   imem_rvalid/imem_rdata  in-order response, at most one outstanding request
//   stall                   downstream not ready; the presented instruction is held
//   flush / flush_pc        redirect from trap/debug, wins over everything else
//   Branch, BranchType, Jump, JumpReg, ImmExt, SrcA, Zero, signedLess, unsignedLess
//                           next-PC controls, sampled only when the instruction is consumed
//   instr_valid, Instr, PC, PCPlus4
//                           instruction presented to the datapath
//
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched (one per consumed instruction) and
// perf_redirects (one per non-sequential consume plus one per flush), both 32-bit wrapping.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,

    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,

    input  logic            Branch,
    input  logic [2:0]      BranchType,
    input  logic            Jump,
    input  logic            JumpReg,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] SrcA,
    input  logic            Zero,
    input  logic            signedLess,
    input  logic            unsignedLess,

`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_redirects,
`endif

    output logic            instr_valid,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    logic [1:0]      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    // Set when the one outstanding response belongs to a request issued before a flush.
    logic            kill_q;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_rel_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] next_pc;
    logic            br_taken;
    logic            flush_keeps_wait;

    // ------------------------------------------------------------------
    // Next-PC resolution (all sums are XLEN-bit and wrap)
    // ------------------------------------------------------------------
    assign pc_plus4   = pc_q + XLEN'(4);
    assign pc_rel_tgt = pc_q + ImmExt;
    assign jalr_sum   = SrcA + ImmExt;

    always_comb begin
        br_taken = 1'b0;
        case (BranchType)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = signedLess;
            3'b101:  br_taken = !signedLess;
            3'b110:  br_taken = unsignedLess;
            3'b111:  br_taken = !unsignedLess;
            default: br_taken = 1'b0;
        endcase
    end

    // JALR outranks JAL outranks a taken branch. No alignment check beyond clearing
    // bit 0 of the JALR target; whatever is computed is fetched.
    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (Jump || (Branch && br_taken)) begin
            next_pc = pc_rel_tgt;
        end
    end

    // A flush must not issue a new request while a response is still in flight:
    // in REQ the request just left, in WAIT it has not returned yet this cycle.
    assign flush_keeps_wait = (state_q == ST_REQ) ||
                              ((state_q == ST_WAIT) && !imem_rvalid);

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            kill_q  <= 1'b0;
        end else if (flush) begin
            pc_q <= flush_pc;
            if (flush_keeps_wait) begin
                state_q <= ST_WAIT;
                kill_q  <= 1'b1;
            end else begin
                // Any same-cycle response is dropped; nothing is left in flight.
                state_q <= ST_REQ;
                kill_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            // Stale response from before the flush; pc already holds
                            // the redirect target, so just re-request.
                            kill_q  <= 1'b0;
                            state_q <= ST_REQ;
                        end else begin
                            instr_q <= imem_rdata;
                            state_q <= ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_q    <= next_pc;
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_VALID);
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic        consume;
    logic [31:0] fetched_q;
    logic [31:0] redirects_q;

    // A flush takes priority, so a consume never coincides with one.
    assign consume = (state_q == ST_VALID) && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q   <= 32'd0;
            redirects_q <= 32'd0;
        end else begin
            if (consume) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (flush || (consume && (next_pc != pc_plus4))) begin
                redirects_q <= redirects_q + 32'd1;
            end
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit with a variable-latency memory model.
// Latency: memory answers 'lat' cycles after it sees imem_req.
// Backpressure: bench drives stall/flush directly at negative clock edges.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        Branch;
    logic [2:0]  BranchType;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] ImmExt;
    logic [31:0] SrcA;
    logic        Zero;
    logic        signedLess;
    logic        unsignedLess;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    logic [31:0] a;
    logic        sv;
    logic [31:0] tgt;
    logic [6:0]  br_tbl [8];

    fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .Branch       (Branch),
        .BranchType   (BranchType),
        .Jump         (Jump),
        .JumpReg      (JumpReg),
        .ImmExt       (ImmExt),
        .SrcA         (SrcA),
        .Zero         (Zero),
        .signedLess   (signedLess),
        .unsignedLess (unsignedLess),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects),
`endif
        .instr_valid  (instr_valid),
        .Instr        (Instr),
        .PC           (PC),
        .PCPlus4      (PCPlus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word at address 0 is 32'h00500093.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0050_0093 ^ {addr[19:0], 12'h000};
    endfunction

    // Memory model: registers a request at the negedge it is visible, answers lat cycles later.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ctrl();
        Branch       = 1'b0;
        BranchType   = 3'b000;
        Jump         = 1'b0;
        JumpReg      = 1'b0;
        ImmExt       = 32'h0;
        SrcA         = 32'h0;
        Zero         = 1'b0;
        signedLess   = 1'b0;
        unsignedLess = 1'b0;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!instr_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 32'(instr_valid), 32'd1);
    endtask

    // Steps until imem_req, noting whether instr_valid was ever raised on the way.
    task automatic wait_req(input int maxc, output logic [31:0] addr, output logic saw_v);
        int n = 0;
        saw_v = 1'b0;
        while (!imem_req && n < maxc) begin
            saw_v = saw_v | instr_valid;
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        addr = imem_addr;
    endtask

    // Called at a negedge in VALID with stall=1.
    task automatic redirect(input logic [31:0] t);
        flush    = 1'b1;
        flush_pc = t;
        @(negedge clk);
        flush = 1'b0;
        check("flush_req", 32'(imem_req), 32'd1);
        check("flush_addr", imem_addr, t);
        check("flush_valid", 32'(instr_valid), 32'd0);
        wait_valid(20);
        check("flush_pc", PC, t);
    endtask

    // Called at a negedge in VALID with stall=1 and controls set up.
    task automatic consume(input string tag, input logic [31:0] exp);
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        check(tag, imem_addr, exp);
        check("consume_req", 32'(imem_req), 32'd1);
        clear_ctrl();
        wait_valid(20);
        check("consume_instr", Instr, mem_word(exp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // {taken, BranchType, Zero, signedLess, unsignedLess}
        br_tbl = '{7'b1_001_000, 7'b0_001_100, 7'b1_100_010, 7'b0_101_010,
                   7'b1_110_001, 7'b1_111_000, 7'b0_010_111, 7'b0_011_111};
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        clear_ctrl();
        repeat (3) @(negedge clk);

        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", Instr, 32'h0000_0013);
        check("rst_pc", PC, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Cycle 0 (IDLE) .. cycle 4 (second request) with a 1-cycle memory.
        rst_n = 1'b1;
        check("c0_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("c2_req", 32'(imem_req), 32'd0);
        check("c2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("c3_valid", 32'(instr_valid), 32'd1);
        check("c3_pc", PC, 32'h0);
        check("c3_pc4", PCPlus4, 32'h4);
        check("c3_instr", Instr, 32'h0050_0093);
        @(negedge clk);
        check("c4_req", 32'(imem_req), 32'd1);
        check("c4_addr", imem_addr, 32'h4);
        stall = 1'b1;
        wait_valid(20);
        check("seq_pc", PC, 32'h4);

        // BEQ at 0x10, offset -8.
        redirect(32'h10);
        Branch = 1'b1; BranchType = 3'b000; ImmExt = 32'hFFFF_FFF8; Zero = 1'b1;
        consume("beq_taken", 32'h8);
        redirect(32'h10);
        Branch = 1'b1; BranchType = 3'b000; ImmExt = 32'hFFFF_FFF8; Zero = 1'b0;
        consume("beq_not_taken", 32'h14);

        // Remaining branch conditions at 0x100 with offset 0x40.
        for (int i = 0; i < 8; i++) begin
            logic [6:0] e;
            e = br_tbl[i];
            redirect(32'h100);
            Branch       = 1'b1;
            BranchType   = e[5:3];
            Zero         = e[2];
            signedLess   = e[1];
            unsignedLess = e[0];
            ImmExt       = 32'h40;
            consume("branch_type", e[6] ? 32'h140 : 32'h104);
        end

        // JALR, JAL+JALR together, JAL alone.
        JumpReg = 1'b1; SrcA = 32'h101; ImmExt = 32'h4;
        consume("jalr", 32'h104);
        Jump = 1'b1; JumpReg = 1'b1; SrcA = 32'h201; ImmExt = 32'h10;
        consume("jal_jalr", 32'h210);
        Jump = 1'b1; ImmExt = 32'hFFFF_FF00;
        consume("jal", 32'h110);

        // Stall held for 5 cycles in VALID.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pc", PC, 32'h110);
            check("stall_instr", Instr, mem_word(32'h110));
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        check("unstall_req", 32'(imem_req), 32'd1);
        check("unstall_addr", imem_addr, 32'h114);
        @(negedge clk);
        check("unstall_pulse", 32'(imem_req), 32'd0);
        wait_valid(20);

        // Flush one cycle after the request, memory latency 4.
        lat   = 4;
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        check("lat4_addr", imem_addr, 32'h118);
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = 32'h200;
        @(negedge clk);
        flush = 1'b0;
        wait_req(20, a, sv);
        check("wait_flush_novalid", 32'(sv), 32'd0);
        check("wait_flush_addr", a, 32'h200);
        wait_valid(20);
        check("wait_flush_pc", PC, 32'h200);
        check("wait_flush_instr", Instr, mem_word(32'h200));
        lat = 1;

        // Flush in REQ (k=0) and in WAIT with same-cycle response (k=1).
        for (int k = 0; k < 2; k++) begin
            tgt   = 32'h300 + 32'(k) * 32'h40;
            stall = 1'b0;
            @(negedge clk);
            stall = 1'b1;
            check("pre_flush_req", 32'(imem_req), 32'd1);
            if (k == 1) @(negedge clk);
            flush    = 1'b1;
            flush_pc = tgt;
            @(negedge clk);
            flush = 1'b0;
            wait_req(20, a, sv);
            check("kill_novalid", 32'(sv), 32'd0);
            check("kill_addr", a, tgt);
            wait_valid(20);
            check("kill_pc", PC, tgt);
            check("kill_instr", Instr, mem_word(tgt));
        end

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4, 32'h0);
        consume("wrap_next", 32'h0);

        // Reset pulsed while waiting on a latency-4 response.
        lat   = 4;
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        check("rstw_addr", imem_addr, 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstw_valid", 32'(instr_valid), 32'd0);
        check("rstw_req", 32'(imem_req), 32'd0);
        check("rstw_pc", PC, 32'h0);
        check("rstw_instr", Instr, 32'h0000_0013);
        repeat (3) @(negedge clk);
        lat   = 1;
        rst_n = 1'b1;
        check("rstw_idle", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("rstw_req1", 32'(imem_req), 32'd1);
        check("rstw_addr1", imem_addr, 32'h0);
        wait_valid(20);
        check("rstw_instr1", Instr, 32'h0050_0093);
        check("rstw_pc1", PC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
